// File: rtl/ps2_mouse_host_ctrl_if.sv
// Handshake bundle between the mouse host controller and the PS/2 frame reader/sender pair.
// master = controller side, slave = reader/sender side.
interface ps2_mouse_host_ctrl_if;
  logic        rx_ready;
  logic [10:0] rx_word;
  logic        tx_busy;
  logic        tx_send;
  logic [9:0]  tx_frame;

  modport master (input rx_ready, rx_word, tx_busy, output tx_send, tx_frame);
  modport slave  (output rx_ready, rx_word, tx_busy, input tx_send, tx_frame);
endinterface

// File: rtl/ps2_mouse_host_ctrl.sv
// PS/2 mouse bring-up sequencer (reset, BAT/ID, enable reporting) and 3-byte
// movement packet assembler sitting on top of a frame reader/sender pair.
module ps2_mouse_host_ctrl #(
  parameter logic [31:0] RESP_TIMEOUT = 32'd50_000_000,
  parameter logic [31:0] PKT_GAP      = 32'd200_000,
  parameter logic [1:0]  MAX_RETRY    = 2'd3
) (
  input  logic                  ck,
  input  logic                  reset,
  ps2_mouse_host_ctrl_if.master ps2,
  output logic                  pkt_valid,
  output logic [2:0]            pkt_btn,
  output logic [8:0]            pkt_dx,
  output logic [8:0]            pkt_dy,
  output logic [1:0]            pkt_ovf,
  output logic                  streaming,
  output logic                  error,
  output logic [3:0]            state_dbg
);

  typedef enum logic [3:0] {
    SEND_RST   = 4'd0,
    TXWAIT_RST = 4'd1,
    WAIT_ACK1  = 4'd2,
    WAIT_BAT   = 4'd3,
    WAIT_ID    = 4'd4,
    SEND_EN    = 4'd5,
    TXWAIT_EN  = 4'd6,
    WAIT_ACK2  = 4'd7,
    STREAM     = 4'd8,
    ERROR      = 4'd9
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d, gap_q, gap_d;
  logic [1:0]  retry_q, retry_d, idx_q, idx_d;
  logic        seen_busy_q, seen_busy_d;
  logic [7:0]  b0_q, b0_d, b1_q, b1_d;
  logic        tx_send_q, tx_send_d;
  logic [9:0]  tx_frame_q, tx_frame_d;
  logic        pkt_valid_q, pkt_valid_d;
  logic [2:0]  pkt_btn_q, pkt_btn_d;
  logic [8:0]  pkt_dx_q, pkt_dx_d, pkt_dy_q, pkt_dy_d;
  logic [1:0]  pkt_ovf_q, pkt_ovf_d;

  logic [7:0]  rx_data;
  logic        rx_good, rx_take, fail;
  logic [1:0]  eff_idx;

  function automatic logic [9:0] frame_of(input logic [7:0] d);
    logic [7:0] r;
    r = {<<{d}};
    return {r, ~(^d), 1'b1};
  endfunction

  // Wire order on rx_word is d0 first, so the data byte is bit-reversed.
  always_comb begin
    rx_data = {<<{ps2.rx_word[9:2]}};
    rx_good = ~ps2.rx_word[10] & ps2.rx_word[0] & (^{rx_data, ps2.rx_word[1]});
    rx_take = ps2.rx_ready & ~ps2.tx_busy &
              (state_q inside {WAIT_ACK1, WAIT_BAT, WAIT_ID, WAIT_ACK2, STREAM});
  end

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    seen_busy_d = seen_busy_q;
    idx_d       = idx_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    tx_send_d   = 1'b0;
    tx_frame_d  = tx_frame_q;
    pkt_valid_d = 1'b0;
    pkt_btn_d   = pkt_btn_q;
    pkt_dx_d    = pkt_dx_q;
    pkt_dy_d    = pkt_dy_q;
    pkt_ovf_d   = pkt_ovf_q;
    fail        = 1'b0;
    eff_idx     = idx_q;

    unique case (state_q)
      SEND_RST, SEND_EN: begin
        if (!ps2.tx_busy) begin
          tx_send_d   = 1'b1;
          tx_frame_d  = frame_of((state_q == SEND_RST) ? 8'hFF : 8'hF4);
          seen_busy_d = 1'b0;
          state_d     = (state_q == SEND_RST) ? TXWAIT_RST : TXWAIT_EN;
        end
      end
      TXWAIT_RST, TXWAIT_EN: begin
        if (!seen_busy_q) begin
          if (ps2.tx_busy)              seen_busy_d = 1'b1;
          else if (timer_q >= 32'd4)    fail = 1'b1;
        end else if (!ps2.tx_busy) begin
          state_d = (state_q == TXWAIT_RST) ? WAIT_ACK1 : WAIT_ACK2;
        end else if (timer_q >= RESP_TIMEOUT) begin
          fail = 1'b1;
        end
      end
      WAIT_ACK1, WAIT_BAT, WAIT_ID, WAIT_ACK2: begin
        if (rx_take) begin
          if (rx_good && state_q == WAIT_ACK1 && rx_data == 8'hFA)      state_d = WAIT_BAT;
          else if (rx_good && state_q == WAIT_BAT && rx_data == 8'hAA)  state_d = WAIT_ID;
          else if (rx_good && state_q == WAIT_ID && rx_data == 8'h00)   state_d = SEND_EN;
          else if (rx_good && state_q == WAIT_ACK2 && rx_data == 8'hFA) state_d = STREAM;
          else if (rx_good && state_q == WAIT_ACK1 && rx_data == 8'hFE) state_d = SEND_RST;
          else if (rx_good && state_q == WAIT_ACK2 && rx_data == 8'hFE) state_d = SEND_EN;
          else fail = 1'b1;
        end else if (timer_q >= RESP_TIMEOUT) begin
          fail = 1'b1;
        end
      end
      STREAM: begin
        // An expired gap resyncs first, so a late byte is judged as a fresh byte 0.
        if (idx_q != 2'd0 && gap_q >= PKT_GAP) eff_idx = 2'd0;
        idx_d = eff_idx;
        if (rx_take) begin
          if (!rx_good) begin
            idx_d = 2'd0;
          end else if (eff_idx == 2'd0) begin
            if (rx_data[3]) begin
              b0_d  = rx_data;
              idx_d = 2'd1;
            end
          end else if (eff_idx == 2'd1) begin
            b1_d  = rx_data;
            idx_d = 2'd2;
          end else begin
            pkt_valid_d = 1'b1;
            pkt_btn_d   = b0_q[2:0];
            pkt_dx_d    = {b0_q[4], b1_q};
            pkt_dy_d    = {b0_q[5], rx_data};
            pkt_ovf_d   = b0_q[7:6];
            idx_d       = 2'd0;
          end
        end
      end
      ERROR: ;
      default: state_d = ERROR;
    endcase

    if (fail) begin
      retry_d = retry_q + 2'd1;
      state_d = (retry_q + 2'd1 == MAX_RETRY) ? ERROR : SEND_RST;
    end

    timer_d = (state_d != state_q || rx_take) ? '0 : timer_q + 32'd1;
    gap_d   = (idx_d == 2'd0 || rx_take) ? '0 : gap_q + 32'd1;
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      state_q     <= SEND_RST;
      timer_q     <= '0;
      gap_q       <= '0;
      retry_q     <= '0;
      idx_q       <= '0;
      seen_busy_q <= 1'b0;
      b0_q        <= '0;
      b1_q        <= '0;
      tx_send_q   <= 1'b0;
      tx_frame_q  <= '0;
      pkt_valid_q <= 1'b0;
      pkt_btn_q   <= '0;
      pkt_dx_q    <= '0;
      pkt_dy_q    <= '0;
      pkt_ovf_q   <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      gap_q       <= gap_d;
      retry_q     <= retry_d;
      idx_q       <= idx_d;
      seen_busy_q <= seen_busy_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      tx_send_q   <= tx_send_d;
      tx_frame_q  <= tx_frame_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_btn_q   <= pkt_btn_d;
      pkt_dx_q    <= pkt_dx_d;
      pkt_dy_q    <= pkt_dy_d;
      pkt_ovf_q   <= pkt_ovf_d;
    end
  end

  assign ps2.tx_send  = tx_send_q;
  assign ps2.tx_frame = tx_frame_q;
  assign pkt_valid    = pkt_valid_q;
  assign pkt_btn      = pkt_btn_q;
  assign pkt_dx       = pkt_dx_q;
  assign pkt_dy       = pkt_dy_q;
  assign pkt_ovf      = pkt_ovf_q;
  assign streaming    = (state_q == STREAM);
  assign error        = (state_q == ERROR);
  assign state_dbg    = state_q;

endmodule
